// File: rtl/alu_issue_queue.sv
// alu_issue_queue: operand/command staging FIFO in front of the 16-bit
// accumulator ALU. Commands are sanitised on entry and issued one per
// clock from registers. NOOP is driven whenever nothing can issue.
module alu_issue_queue #(
  parameter int W     = 16,
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          clk,
  input  logic          clear,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [3:0]    in_opcode,
  input  logic [W-1:0]  in_a,
  input  logic [W-1:0]  in_b,
  input  logic          stall,
  input  logic          err_clr,
  output logic [3:0]    opcode,
  output logic [W-1:0]  input1,
  output logic [W-1:0]  input2,
  output logic          issued,
  output logic [AW:0]   count,
  output logic [1:0]    err
);

  typedef enum logic [3:0] {
    OP_NOOP  = 4'b0000,
    OP_ADD   = 4'b0001,
    OP_SUB   = 4'b0010,
    OP_MULT  = 4'b0011,
    OP_DIV   = 4'b0100,
    OP_AND   = 4'b0101,
    OP_OR    = 4'b0110,
    OP_XOR   = 4'b0111,
    OP_NOT   = 4'b1000,
    OP_RESET = 4'b1111
  } opcode_e;

  typedef struct packed {
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
  } entry_t;

  entry_t          mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            push;
  logic            pop;
  entry_t          wr_entry;
  entry_t          head;
  logic [1:0]      err_event;

  // Handshake: accept while not full; issue whenever not stalled and not empty.
  assign in_ready = (count < (AW+1)'(DEPTH));
  assign push     = in_valid & in_ready;
  assign pop      = ~stall & (count != '0);
  assign head     = mem[rd_ptr];

  // Sanitise the incoming command and flag the error it would raise on push.
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    wr_entry  = '{op: in_opcode, a: in_a, b: in_b};
    err_event = 2'b00;
    if (in_opcode inside {[4'b1001:4'b1110]}) begin
      wr_entry.op  = OP_NOOP;
      err_event[0] = push;
    end else if (in_opcode == OP_DIV && in_b == '0) begin
      wr_entry.op  = OP_NOOP;
      err_event[1] = push;
    end
  end

  // Entry storage: written on push only.
  // NOTE: the array has no reset; stale contents are never visible because
  // count and the pointers are reset, and skipping it keeps this plain RAM.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wr_entry;
    end
  end

  // Pointers and occupancy; simultaneous push and pop leave count unchanged.
  always_ff @(posedge clk or negedge clear) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      count <= count + (AW+1)'(1);
      else if (pop && !push) count <= count - (AW+1)'(1);
    end
  end

  // Registered ALU drive: pop the head or substitute NOOP holding operands.
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      opcode <= OP_NOOP;
      input1 <= '0;
      input2 <= '0;
      issued <= 1'b0;
    end else if (pop) begin
      opcode <= head.op;
      input1 <= head.a;
      input2 <= head.b;
      issued <= 1'b1;
    end else begin
      opcode <= OP_NOOP;
      issued <= 1'b0;
    end
  end

  // Sticky error flags; a new event on the clearing edge wins.
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      err <= 2'b00;
    end else begin
      err <= (err & ~{2{err_clr}}) | err_event;
    end
  end

endmodule

// File: tb/tb_alu_issue_queue.sv
// tb_alu_issue_queue: directed scenarios plus randomized traffic, all
// checked against a queue-based reference model of the issue queue.
module tb_alu_issue_queue;

  localparam int W     = 16;
  localparam int DEPTH = 4;
  localparam int AW    = 2;

  logic          clk = 1'b0;
  logic          clear;
  logic          in_valid;
  logic          in_ready;
  logic [3:0]    in_opcode;
  logic [W-1:0]  in_a;
  logic [W-1:0]  in_b;
  logic          stall;
  logic          err_clr;
  logic [3:0]    opcode;
  logic [W-1:0]  input1;
  logic [W-1:0]  input2;
  logic          issued;
  logic [AW:0]   count;
  logic [1:0]    err;

  int n_checks = 0;
  int n_errors = 0;

  alu_issue_queue #(.W(W), .DEPTH(DEPTH), .AW(AW)) dut (
    .clk       (clk),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_opcode (in_opcode),
    .in_a      (in_a),
    .in_b      (in_b),
    .stall     (stall),
    .err_clr   (err_clr),
    .opcode    (opcode),
    .input1    (input1),
    .input2    (input2),
    .issued    (issued),
    .count     (count),
    .err       (err)
  );

  always #5 clk = ~clk;

  // Reference model: a queue of commands plus the expected output registers.
  typedef struct {
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
  } cmd_t;

  cmd_t         q[$];
  logic [3:0]   m_op;
  logic [W-1:0] m_in1;
  logic [W-1:0] m_in2;
  logic         m_issued;
  logic [1:0]   m_err;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    q.delete();
    m_op     = 4'd0;
    m_in1    = '0;
    m_in2    = '0;
    m_issued = 1'b0;
    m_err    = 2'b00;
  endfunction

  task automatic check_outputs(input string where);
    check({where, ".opcode"}, 32'(opcode), 32'(m_op));
    check({where, ".input1"}, 32'(input1), 32'(m_in1));
    check({where, ".input2"}, 32'(input2), 32'(m_in2));
    check({where, ".issued"}, 32'(issued), 32'(m_issued));
    check({where, ".count"},  32'(count),  q.size());
    check({where, ".err"},    32'(err),    32'(m_err));
  endtask

  // One clock: drive inputs, let an edge pass, advance the model, compare.
  task automatic cycle(input logic v, input logic [3:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic st, input logic ec);
    bit   do_push;
    bit   do_pop;
    cmd_t c;
    in_valid  = v;
    in_opcode = op;
    in_a      = a;
    in_b      = b;
    stall     = st;
    err_clr   = ec;
    #1;
    check("in_ready", 32'(in_ready), (q.size() < DEPTH) ? 1 : 0);
    do_push = v && (q.size() < DEPTH);
    do_pop  = !st && (q.size() > 0);
    @(posedge clk);
    #1;
    if (do_pop) begin
      c        = q.pop_front();
      m_op     = c.op;
      m_in1    = c.a;
      m_in2    = c.b;
      m_issued = 1'b1;
    end else begin
      m_op     = 4'd0;
      m_issued = 1'b0;
    end
    if (ec) m_err = 2'b00;
    if (do_push) begin
      c.op = op;
      c.a  = a;
      c.b  = b;
      if (op >= 4'd9 && op <= 4'd14) begin
        c.op     = 4'd0;
        m_err[0] = 1'b1;
      end else if (op == 4'd4 && b == 0) begin
        c.op     = 4'd0;
        m_err[1] = 1'b1;
      end
      q.push_back(c);
    end
    check_outputs("cyc");
  endtask

  task automatic idle(input logic st);
    cycle(1'b0, 4'd0, '0, '0, st, 1'b0);
  endtask

  task automatic push(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic st);
    cycle(1'b1, op, a, b, st, 1'b0);
  endtask

  // Drop clear between edges, verify immediate effect, hold over one edge.
  task automatic async_reset();
    #2;
    clear    = 1'b0;
    in_valid = 1'b0;
    #1;
    model_reset();
    check_outputs("rst_now");
    check("rst_now.in_ready", 32'(in_ready), 1);
    @(posedge clk);
    #1;
    check_outputs("rst_hold");
    clear = 1'b1;
  endtask

  initial begin
    model_reset();
    clear     = 1'b0;
    in_valid  = 1'b0;
    in_opcode = 4'd0;
    in_a      = '0;
    in_b      = '0;
    stall     = 1'b0;
    err_clr   = 1'b0;

    // Reset then idle.
    repeat (2) @(posedge clk);
    #1;
    check_outputs("reset");
    check("reset.in_ready", 32'(in_ready), 1);
    clear = 1'b1;
    repeat (3) idle(1'b0);

    // Basic flow: single ADD, then NOOP with operands held.
    push(4'd1, 16'd1, 16'd1, 1'b0);
    idle(1'b0);
    check("basic.opcode", 32'(opcode), 32'h1);
    idle(1'b0);
    check("basic.hold", 32'(input1), 32'h1);

    // Fill under stall, refused 5th push, then drain in order.
    push(4'd2, 16'd3, 16'd1, 1'b1);
    push(4'd3, 16'd2, 16'd2, 1'b1);
    push(4'd5, 16'd15, 16'd9, 1'b1);
    push(4'd6, 16'd10, 16'd5, 1'b1);
    check("fill.count", 32'(count), 32'd4);
    push(4'd7, 16'd11, 16'd13, 1'b1);
    check("fill.refused", 32'(count), 32'd4);
    repeat (5) idle(1'b0);

    // Steady push+pop at count 2 across pointer wrap.
    push(4'd1, 16'd100, 16'd1, 1'b1);
    push(4'd1, 16'd101, 16'd1, 1'b1);
    for (int i = 0; i < 8; i++) begin
      push(4'd2, W'(200 + i), W'(i), 1'b0);
      check("wrap.count", 32'(count), 32'd2);
    end
    repeat (3) idle(1'b0);

    // Sanitising and error clear.
    push(4'd4, 16'd8, 16'd0, 1'b0);
    push(4'b1010, 16'd5, 16'd5, 1'b0);
    idle(1'b0);
    check("san.err", 32'(err), 32'h3);
    cycle(1'b0, 4'd0, '0, '0, 1'b0, 1'b1);
    check("san.clr", 32'(err), 32'h0);
    push(4'd4, 16'd8, 16'd2, 1'b0);
    idle(1'b0);
    check("san.div", 32'(opcode), 32'h4);
    // err_clr coinciding with a new error: set wins.
    cycle(1'b1, 4'b1100, 16'd1, 16'd1, 1'b0, 1'b1);
    check("san.setwins", 32'(err), 32'h1);
    cycle(1'b0, 4'd0, '0, '0, 1'b0, 1'b1);

    // Async reset mid-stream with three queued entries.
    push(4'd1, 16'd7, 16'd7, 1'b1);
    push(4'd2, 16'd8, 16'd8, 1'b1);
    push(4'd3, 16'd9, 16'd9, 1'b1);
    stall = 1'b0;
    async_reset();
    push(4'd8, 16'h55, 16'h0, 1'b0);
    idle(1'b0);
    check("post_rst.opcode", 32'(opcode), 32'h8);
    check("post_rst.input1", 32'(input1), 32'h55);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      logic [3:0]   r_op;
      logic [W-1:0] r_a;
      logic [W-1:0] r_b;
      r_op = 4'($urandom_range(15, 0));
      r_a  = W'($urandom);
      r_b  = ($urandom_range(3, 0) == 0) ? '0 : W'($urandom);
      cycle(1'($urandom_range(1, 0)), r_op, r_a, r_b,
            ($urandom_range(2, 0) == 0), ($urandom_range(7, 0) == 0));
      if ($urandom_range(99, 0) == 0) async_reset();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
